// File: rtl/crc8_serial.sv
// crc8_serial: bit-serial CRC-8 engine, MSB first, one message bit per clock.
// Bytes arrive over a valid/ready handshake. Each frame's CRC is presented on
// an output valid/ready handshake once the byte flagged as last has been
// fully shifted in. There is no reflection and no final XOR.
module crc8_serial #(
    parameter logic [7:0] POLY = 8'h07,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_crc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] crc;
    logic [7:0] sh;
    logic [2:0] cnt;
    logic       last;

    logic       accept;
    logic       release_out;
    logic       fb;

    // All outputs are decoded from registers, so none of them depends
    // combinationally on an input.
    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign out_crc     = crc;

    assign accept      = in_valid & in_ready;
    assign release_out = out_valid & out_ready;

    // Feedback bit: the outgoing CRC MSB combined with the next message bit.
    assign fb          = crc[7] ^ sh[7];

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of the order of statements.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: accept a byte, shift eight bits, then either return
    // for the next byte or hold the result until the consumer takes it.
    // NOTE: state_nxt gets a default before the case so that no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 3'd7) begin
                    state_nxt = last ? DONE : IDLE;
                end
            end
            DONE: begin
                if (release_out) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load the byte on acceptance, run the LFSR one bit per cycle
    // while shifting, and re-seed the CRC once the result has been taken.
    // A reset discards any partial byte or frame.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            crc  <= INIT;
            sh   <= 8'h00;
            cnt  <= 3'd0;
            last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh   <= in_data;
                        last <= in_last;
                        cnt  <= 3'd0;
                    end
                end
                SHIFT: begin
                    crc <= {crc[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
                    sh  <= {sh[6:0], 1'b0};
                    cnt <= cnt + 3'd1;
                end
                DONE: begin
                    if (release_out) begin
                        crc <= INIT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc8_serial.sv
// tb_crc8_serial: scoreboard bench for crc8_serial. Expected CRCs are queued
// when a frame is driven and popped when the engine presents a result.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_crc8_serial;

    logic       ck = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_crc;

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;

    logic [7:0] exp_q[$];

    logic [7:0] sb_data[3] = '{8'h01, 8'hFF, 8'h00};
    logic [7:0] sb_exp[3]  = '{8'h07, 8'hF3, 8'h00};

    crc8_serial dut (
        .ck        (ck),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_crc   (out_crc)
    );

    always #5 ck = ~ck;

    // Cycle count: value k means rising edge k has occurred.
    always @(posedge ck) cyc <= cyc + 1;

    // Absolute bound on the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
        $fatal(1, "watchdog expired");
    end

    // Offer a byte starting at the current falling edge and wait (bounded)
    // until it is taken. acc is the cycle count just before the accepting
    // edge. Returns on the falling edge after acceptance with in_valid high.
    task automatic send_byte(input logic [7:0] d, input logic l, output int acc);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 40) begin
            @(negedge ck);
            n++;
        end
        vectors++;
        if (!in_ready) begin
            miscompares++;
            $display("FAIL send_timeout: byte %h, in_ready=%b after %0d cycles, required 1", d, in_ready, n);
        end
        acc = cyc;
        @(negedge ck);
    endtask

    // Wait (bounded) for out_valid; returns on the falling edge where it is
    // first seen, with the CRC on display and the cycle count.
    task automatic wait_out(output logic [7:0] c, output int at);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge ck);
            n++;
        end
        vectors++;
        if (!out_valid) begin
            miscompares++;
            $display("FAIL out_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
        end
        c  = out_crc;
        at = cyc;
    endtask

    task automatic pop_exp(output logic [7:0] e);
        if (exp_q.size() == 0) begin
            e = 8'hxx;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        in_last   = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge ck);
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_in_ready: got %b, required 1", in_ready);
            end
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_out_valid: got %b, required 0", out_valid);
            end
            vectors++;
            if (out_crc !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_out_crc: got %h, required 00", out_crc);
            end
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge ck);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_crc !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b out_crc=%h, required 1 0 00",
                     in_ready, out_valid, out_crc);
        end
    endtask

    task automatic test_single_byte;
        int         acc;
        int         at;
        logic [7:0] c;
        logic [7:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(sb_exp[i]);
            send_byte(sb_data[i], 1'b1, acc);
            in_valid = 1'b0;
            wait_out(c, at);
            pop_exp(e);
            vectors++;
            if (c !== e) begin
                miscompares++;
                $display("FAIL single_crc: byte %h got %h, required %h", sb_data[i], c, e);
            end
            vectors++;
            if (at - acc !== 9) begin
                miscompares++;
                $display("FAIL single_latency: byte %h got %0d cycles, required 9", sb_data[i], at - acc);
            end
            @(negedge ck);
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL single_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
            end
        end
    endtask

    task automatic test_frame_123456789;
        int         accs[9];
        int         at;
        logic [7:0] c;
        logic [7:0] e;
        logic [7:0] d;
        out_ready = 1'b1;
        exp_q.push_back(8'hF4);
        for (int i = 0; i < 9; i++) begin
            d = 8'h31 + 8'(i);
            send_byte(d, (i == 8), accs[i]);
        end
        in_valid = 1'b0;
        for (int i = 1; i < 9; i++) begin
            vectors++;
            if (accs[i] - accs[i-1] !== 9) begin
                miscompares++;
                $display("FAIL frame_spacing: byte %0d got %0d cycles, required 9", i, accs[i] - accs[i-1]);
            end
        end
        wait_out(c, at);
        pop_exp(e);
        vectors++;
        if (c !== e) begin
            miscompares++;
            $display("FAIL frame_crc: got %h, required %h", c, e);
        end
        vectors++;
        if (at - accs[8] !== 9) begin
            miscompares++;
            $display("FAIL frame_latency: got %0d cycles, required 9", at - accs[8]);
        end
        @(negedge ck);
    endtask

    task automatic test_backpressure;
        int         acc;
        int         at;
        logic [7:0] c;
        logic [7:0] e;
        out_ready = 1'b0;
        exp_q.push_back(8'hF3);
        send_byte(8'hFF, 1'b1, acc);
        // Keep offering a different byte; it must be ignored throughout.
        in_data = 8'h55;
        in_last = 1'b1;
        wait_out(c, at);
        pop_exp(e);
        vectors++;
        if (c !== e) begin
            miscompares++;
            $display("FAIL bp_crc: got %h, required %h", c, e);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge ck);
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_crc !== e) begin
                miscompares++;
                $display("FAIL bp_hold: cycle %0d out_valid=%b in_ready=%b out_crc=%h, required 1 0 %h",
                         i, out_valid, in_ready, out_crc, e);
            end
        end
        out_ready = 1'b1;
        @(negedge ck);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_crc !== 8'h00) begin
            miscompares++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b out_crc=%h, required 0 1 00",
                     out_valid, in_ready, out_crc);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        int         acc1;
        int         acc2;
        int         at1;
        int         at2;
        logic [7:0] c;
        logic [7:0] e;
        out_ready = 1'b1;
        exp_q.push_back(8'h07);
        exp_q.push_back(8'hF3);
        send_byte(8'h01, 1'b1, acc1);
        in_valid = 1'b0;
        wait_out(c, at1);
        pop_exp(e);
        vectors++;
        if (c !== e) begin
            miscompares++;
            $display("FAIL b2b_first_crc: got %h, required %h", c, e);
        end
        @(negedge ck);
        send_byte(8'hFF, 1'b1, acc2);
        in_valid = 1'b0;
        vectors++;
        if (acc2 !== at1 + 1) begin
            miscompares++;
            $display("FAIL b2b_accept_gap: accepted at %0d, required %0d", acc2, at1 + 1);
        end
        wait_out(c, at2);
        pop_exp(e);
        vectors++;
        if (c !== e) begin
            miscompares++;
            $display("FAIL b2b_second_crc: got %h, required %h", c, e);
        end
        @(negedge ck);
    endtask

    task automatic test_reset_mid_shift;
        int         acc;
        int         at;
        logic [7:0] c;
        logic [7:0] e;
        out_ready = 1'b1;
        send_byte(8'hFF, 1'b1, acc);
        in_valid = 1'b0;
        // Four more edges bring the bit counter to 4.
        repeat (4) @(negedge ck);
        rst = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_crc !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset_async: in_ready=%b out_crc=%h, required 1 00", in_ready, out_crc);
        end
        @(negedge ck);
        rst = 1'b0;
        @(negedge ck);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_crc !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset_idle: in_ready=%b out_valid=%b out_crc=%h, required 1 0 00",
                     in_ready, out_valid, out_crc);
        end
        exp_q.push_back(8'h07);
        send_byte(8'h01, 1'b1, acc);
        in_valid = 1'b0;
        wait_out(c, at);
        pop_exp(e);
        vectors++;
        if (c !== e) begin
            miscompares++;
            $display("FAIL mid_reset_crc: got %h, required %h", c, e);
        end
        vectors++;
        if (at - acc !== 9) begin
            miscompares++;
            $display("FAIL mid_reset_latency: got %0d cycles, required 9", at - acc);
        end
        @(negedge ck);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_frame_123456789();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
